fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues one 32-bit fetch at a time on the

---
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Connection between the fetch stage, the instruction bus and the decode stage.
// The master modport is the fetch stage; the slave modport is the bus/decode side.
interface fetch_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] pc;

  modport master (
    output ireq_valid, ireq_addr, valid, instr, pc,
    input  iresp_ok, iresp_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr, valid, instr, pc,
    output iresp_ok, iresp_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one fetch in flight, buffers one
// instruction across a stall and drops wrong-path responses after a redirect.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        ireq_valid_q, ireq_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_out_q, pc_out_d;

  logic        deliver_s;
  logic [31:0] del_instr_s;
  logic [63:0] del_pc_s;
  logic [63:0] redir_pc_s;
  logic [63:0] pc_inc_s;

  assign redir_pc_s = {bus.redirect_pc[63:2], 2'b00};
  assign pc_inc_s   = pc_q + 64'd4;

  // Fetch FSM: PC update, request address, hold buffer and delivery select.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    deliver_s    = 1'b0;
    del_instr_s  = 32'd0;
    del_pc_s     = 64'd0;
    case (state_q)
      S_IDLE: begin
        pc_d       = bus.redirect ? redir_pc_s : pc_q;
        req_addr_d = pc_d;
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (bus.redirect) begin
          pc_d = redir_pc_s;
          if (bus.iresp_ok) begin
            req_addr_d = redir_pc_s;
            state_d    = S_REQ;
          end else begin
            // The bus cannot cancel, so wait out the old response.
            state_d = S_DISCARD;
          end
        end else if (bus.iresp_ok) begin
          pc_d = pc_inc_s;
          if (bus.stall) begin
            hold_instr_d = bus.iresp_data;
            hold_pc_d    = req_addr_q;
            state_d      = S_HOLD;
          end else begin
            deliver_s   = 1'b1;
            del_instr_s = bus.iresp_data;
            del_pc_s    = req_addr_q;
            req_addr_d  = pc_inc_s;
            state_d     = S_REQ;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        pc_d = bus.redirect ? redir_pc_s : pc_q;
        if (bus.iresp_ok) begin
          req_addr_d = pc_d;
          state_d    = S_REQ;
        end else begin
          state_d = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (bus.redirect) begin
          pc_d       = redir_pc_s;
          req_addr_d = redir_pc_s;
          state_d    = S_REQ;
        end else if (!bus.stall) begin
          deliver_s   = 1'b1;
          del_instr_s = hold_instr_q;
          del_pc_s    = hold_pc_q;
          req_addr_d  = pc_q;
          state_d     = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ireq_valid_d = (state_d == S_REQ) || (state_d == S_DISCARD);
  end

  // Decode-side output register: redirect kills, stall freezes, else load or bubble.
  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    if (bus.redirect) begin
      valid_d = 1'b0;
    end else if (bus.stall) begin
      valid_d = valid_q;
    end else if (deliver_s) begin
      valid_d  = 1'b1;
      instr_d  = del_instr_s;
      pc_out_d = del_pc_s;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= 64'd0;
      ireq_valid_q <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 64'd0;
      valid_q      <= 1'b0;
      instr_q      <= 32'd0;
      pc_out_q     <= 64'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      ireq_valid_q <= ireq_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
    end
  end

  assign bus.ireq_valid = ireq_valid_q;
  assign bus.ireq_addr  = req_addr_q;
  assign bus.valid      = valid_q;
  assign bus.instr      = instr_q;
  assign bus.pc         = pc_out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a 2-cycle-latency memory responder, directed
// stall/redirect/reset scenarios, and a monitor checking each delivery in order.
module tb_fetch_stage;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_if bus();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int deliv_cnt = 0;
  int cyc = 0;
  int deliv_cyc [16];
  logic [63:0] exp_q [$];

  logic pending = 1'b0;
  int   rcnt = 0;
  logic resp_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  // Monitor: each newly loaded output must match the head of the expected queue.
  initial begin : monitor
    logic upd;
    logic [63:0] exp_pc;
    forever begin
      @(posedge clk);
      cyc++;
      upd = !bus.stall || bus.redirect;
      #1;
      if (rst_n && bus.valid && upd) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_delivery pc=%h instr=%h required=no delivery", bus.pc, bus.instr);
        end else begin
          exp_pc = exp_q.pop_front();
          if (bus.pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            failures++;
            $display("FAIL delivery pc=%h instr=%h required pc=%h instr=%h",
                     bus.pc, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
        if (deliv_cnt < 16) deliv_cyc[deliv_cnt] = cyc;
        deliv_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle: at the falling edge retire the last pulse, then run the responder.
  task automatic tick();
    @(negedge clk);
    if (bus.iresp_ok) begin
      bus.iresp_ok = 1'b0;
      pending = 1'b0;
    end
    if (resp_en) begin
      if (!pending) begin
        if (bus.ireq_valid) begin
          pending = 1'b1;
          rcnt = 0;
        end
      end else begin
        rcnt++;
        if (rcnt == 2) begin
          bus.iresp_ok   = 1'b1;
          bus.iresp_data = mem_word(bus.ireq_addr);
        end
      end
    end
  endtask

  task automatic wait_deliv(input int n, input string name);
    int b = 0;
    while (deliv_cnt < n && b < 40) begin
      tick();
      b++;
    end
    chk({name, "_count"}, 64'(deliv_cnt), 64'(n));
  endtask

  task automatic wait_addr(input logic [63:0] a, input string name);
    int b = 0;
    while (!(bus.ireq_valid && bus.ireq_addr == a) && b < 20) begin
      tick();
      b++;
    end
    chk(name, bus.ireq_addr, a);
  endtask

  initial begin : stim
    int b;
    bus.iresp_ok    = 1'b0;
    bus.iresp_data  = 32'd0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 64'd0;

    // Reset values
    repeat (3) tick();
    chk("rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
    chk("rst_ireq_addr", bus.ireq_addr, 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_pc", bus.pc, 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);

    // Sequential fetch, 3-cycle cadence
    rst_n = 1'b1;
    resp_en = 1'b1;
    exp_q.push_back(64'h0000_0000_8000_0000);
    exp_q.push_back(64'h0000_0000_8000_0004);
    exp_q.push_back(64'h0000_0000_8000_0008);
    tick();
    chk("first_req_valid", 64'(bus.ireq_valid), 64'd1);
    chk("first_req_addr", bus.ireq_addr, RESET_PC);
    wait_deliv(3, "seq");
    chk("cadence_1", 64'(deliv_cyc[1] - deliv_cyc[0]), 64'd3);
    chk("cadence_2", 64'(deliv_cyc[2] - deliv_cyc[1]), 64'd3);

    // Stall 5 cycles while the 0x0C response arrives
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_frozen_pc", bus.pc, 64'h0000_0000_8000_0008);
      chk("stall_frozen_valid", 64'(bus.valid), 64'd1);
    end
    chk("hold_no_req", 64'(bus.ireq_valid), 64'd0);
    exp_q.push_back(64'h0000_0000_8000_000C);
    bus.stall = 1'b0;
    wait_deliv(4, "hold_release");
    resp_en = 1'b0;

    // Redirect while 0x10 is in flight
    exp_q.push_back(64'h0000_0000_8000_1000);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h0000_0000_8000_1000;
    tick();
    bus.redirect = 1'b0;
    chk("discard_addr_kept", bus.ireq_addr, 64'h0000_0000_8000_0010);
    chk("discard_req_valid", 64'(bus.ireq_valid), 64'd1);
    chk("discard_valid_low", 64'(bus.valid), 64'd0);
    resp_en = 1'b1;
    wait_addr(64'h0000_0000_8000_1000, "redirect_target_addr");
    wait_deliv(5, "redirect");
    resp_en = 1'b1;

    // Redirect and response in the same cycle, target wraps past zero
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0000_0000_0000_0000);
    b = 0;
    while (!bus.iresp_ok && b < 10) begin
      tick();
      b++;
    end
    chk("same_cycle_ok_seen", 64'(bus.iresp_ok), 64'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    chk("same_cycle_next_addr", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_deliv(7, "wrap");
    resp_en = 1'b0;

    // Misaligned redirect target is forced to word alignment
    exp_q.push_back(64'h0000_0000_8000_1000);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h0000_0000_8000_1003;
    tick();
    bus.redirect = 1'b0;
    chk("wrap_req_addr", bus.ireq_addr, 64'h0000_0000_0000_0004);
    resp_en = 1'b1;
    wait_addr(64'h0000_0000_8000_1000, "align_addr");
    wait_deliv(8, "align");
    resp_en = 1'b0;

    // Redirect during HOLD flushes the buffered instruction despite stall
    exp_q.push_back(64'h0000_0000_8000_2000);
    bus.stall = 1'b1;
    resp_en = 1'b1;
    b = 0;
    while (bus.ireq_valid && b < 10) begin
      tick();
      b++;
    end
    chk("hold_entered", 64'(bus.ireq_valid), 64'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h0000_0000_8000_2000;
    tick();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    chk("hold_flush_addr", bus.ireq_addr, 64'h0000_0000_8000_2000);
    chk("hold_flush_valid", 64'(bus.valid), 64'd0);
    wait_deliv(9, "hold_flush");

    // Reset with a request outstanding, then a stray response in IDLE
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
    chk("midrst_ireq_addr", bus.ireq_addr, 64'd0);
    chk("midrst_valid", 64'(bus.valid), 64'd0);
    chk("midrst_pc", bus.pc, 64'd0);
    resp_en = 1'b0;
    pending = 1'b0;
    bus.iresp_ok = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    bus.iresp_ok = 1'b1;
    bus.iresp_data = 32'hDEAD_BEEF;
    tick();
    chk("post_rst_req_valid", 64'(bus.ireq_valid), 64'd1);
    chk("post_rst_req_addr", bus.ireq_addr, RESET_PC);
    chk("post_rst_valid", 64'(bus.valid), 64'd0);
    exp_q.push_back(RESET_PC);
    resp_en = 1'b1;
    wait_deliv(10, "post_rst");
    resp_en = 1'b0;

    repeat (4) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
